mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage load/store unit that sits directly upstream of dram_driver. It takes one memory request per cycle from the EX stage and decodes the address into the DRAM window or the MMIO window.
- For DRAM accesses it drives dram_driver's perip_addr, perip_wdata, perip_mask and dram_wen. It owns the MMIO registers: switches, LEDs and the cycle counter.
- It sign- or zero-extends load data and registers the result to the WB stage.

Parameters:
DRAM_BASE, 32'h8010_0000, base of 256 KiB DRAM window (addr[31:18] compare)
MMIO_SW, 32'h8020_0000, switch input register address (read-only)
MMIO_LED, 32'h8020_0040, LED output register address (read/write)
MMIO_CNT, 32'h8020_0050, cycle counter address (read; any store clears)
LED_W, 24, LED/switch width

Ports:
clk  in  1  clock; all state rises on posedge
rst  in  1  reset, synchronous, active-high
ex_valid  in  1  request present this cycle
ex_is_load  in  1  request is a load
ex_is_store  in  1  request is a store (never both set with ex_is_load)
ex_funct3  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
ex_addr  in  32  byte address
ex_wdata  in  32  store data, right-aligned
ex_rd  in  5  load destination register
perip_addr  out  18  ex_addr[17:0] to dram_driver
perip_wdata  out  32  ex_wdata to dram_driver
perip_mask  out  2  ex_funct3[1:0] (00 byte, 01 half, 10 word)
dram_wen  out  1  DRAM write strobe
perip_rdata  in  32  zero-extended read data from dram_driver (combinational, same cycle)
sw  in  LED_W  switch inputs
led  out  LED_W  LED register
wb_valid  out  1  load result valid
wb_rd  out  5  load destination
wb_data  out  32  extended load data
misalign  out  1  one-cycle pulse on misaligned access
misalign_sticky  out  1  set on any misalign, cleared only by rst

Behaviour:
- Clock port is clk. Reset port is rst, synchronous and active-high. Both are fixed.
- Reset values: wb_valid=0, wb_rd=0, wb_data=0, led=0, counter=0, misalign=0, misalign_sticky=0.
- Reset mid-operation: a request in the same cycle as rst is discarded, and no state is updated from it.
- perip_addr, perip_wdata and perip_mask are combinational passthroughs.
- dram_wen is combinational. It is 1 only when ex_valid & ex_is_store & hit_dram & ~mis.
- hit_dram: ex_addr[31:18] == DRAM_BASE[31:18].
- MMIO hits are exact 32-bit address compares. Any other address is unmapped.
- mis: (half & addr[0]) | (word & addr[1:0]!=0).
- Misaligned access:
  - No DRAM or MMIO write occurs.
  - misalign pulses high in the next cycle and misalign_sticky sets.
  - A misaligned load still produces wb_valid with wb_data=0.
- Load latency is 1 cycle. Read data is selected and extended combinationally, then captured at posedge. wb_valid, wb_rd and wb_data are valid the following cycle. wb_valid is 0 in every cycle without a load.
- Load read sources:
  - DRAM: perip_rdata.
  - MMIO_SW: zero-extended sw.
  - MMIO_LED: zero-extended led.
  - MMIO_CNT: counter.
  - Unmapped: 0.
- Extension:
  - funct3 000: sign-extend from bit 7.
  - funct3 001: sign-extend from bit 15.
  - funct3 100 / 101: zero-extend.
  - funct3 010: full word.
  - MMIO reads are always returned as full word regardless of funct3.
- Stores:
  - To MMIO_LED: led <= ex_wdata[LED_W-1:0] (any width).
  - To MMIO_CNT: counter clears.
  - To MMIO_SW or unmapped addresses: the store is dropped silently.
- Counter:
  - 32-bit, increments every cycle and wraps 32'hFFFF_FFFF -> 0.
  - A clearing store wins over the increment: counter = 0 in the next cycle.
  - A load of MMIO_CNT returns the pre-increment value of the request cycle.
- Back-to-back accesses: a load in cycle N+1 from a DRAM word stored in cycle N returns the new data. The write is committed at the posedge ending cycle N.

Decomposition:
- Shared package mem_pkg:
  - funct3 encodings.
  - mask encoding (MASK_B, MASK_H, MASK_W).
  - MMIO address constants.
  - region enum {REG_DRAM, REG_SW, REG_LED, REG_CNT, REG_NONE}.
- One sub-module, load_extender: combinational funct3 plus raw word to extended word. It is reused by the future cache path.

Test Plan:
- rst high 2 cycles -> all outputs 0. Then ex_valid=0 for 5 cycles -> wb_valid=0; lw MMIO_CNT then returns 5 (±fixed pipeline offset documented in bench).
- sw 0x8010_0008 data 0xDEADBEEF, then lb (funct3 000) at 0x8010_000B -> dram_wen=1 in store cycle only; wb_data=0xFFFFFFDE next cycle. lbu at the same address -> 0x000000DE.
- lh at 0x8010_0001 -> misalign=1 one cycle, misalign_sticky=1, wb_valid=1, wb_data=0. sw at 0x8010_0002 -> dram_wen=0, memory unchanged.
- Store 0x00ABCDEF to MMIO_LED -> led=0xABCDEF next cycle. Store to MMIO_SW with sw=0x123456 -> lw MMIO_SW returns 0x00123456, sw unaffected.
- Counter forced near wrap (run 2^32 cycles via force hook) -> 0xFFFFFFFF then 0. Store to MMIO_CNT in the same cycle as the increment -> 0 next cycle.
- Assert rst in the cycle a store to MMIO_LED is presented -> led stays 0, wb_valid=0 next cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store path.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] MASK_B = 2'b00;
  localparam logic [1:0] MASK_H = 2'b01;
  localparam logic [1:0] MASK_W = 2'b10;

  localparam logic [31:0] DRAM_BASE_ADDR = 32'h8010_0000;
  localparam logic [31:0] MMIO_SW_ADDR   = 32'h8020_0000;
  localparam logic [31:0] MMIO_LED_ADDR  = 32'h8020_0040;
  localparam logic [31:0] MMIO_CNT_ADDR  = 32'h8020_0050;
  localparam int unsigned LED_W_DEF      = 24;

  typedef enum logic [2:0] {
    REG_DRAM,
    REG_SW,
    REG_LED,
    REG_CNT,
    REG_NONE
  } region_e;

endpackage

// File: rtl/load_extender.sv
// Turns a right-aligned raw load word into the architectural result for funct3.
module load_extender
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  // Sign/zero extension selected by funct3; word and unknown codes pass through.
  always_comb begin
    ext = raw;
    case (funct3)
      F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
      F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   ext = {24'h0, raw[7:0]};
      F3_HU:   ext = {16'h0, raw[15:0]};
      F3_W:    ext = raw;
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: DRAM front-end, MMIO registers and WB load register.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter logic [31:0] DRAM_BASE = DRAM_BASE_ADDR,
  parameter logic [31:0] MMIO_SW   = MMIO_SW_ADDR,
  parameter logic [31:0] MMIO_LED  = MMIO_LED_ADDR,
  parameter logic [31:0] MMIO_CNT  = MMIO_CNT_ADDR,
  parameter int unsigned LED_W     = LED_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic             ex_is_store,
  input  logic [2:0]       ex_funct3,
  input  logic [31:0]      ex_addr,
  input  logic [31:0]      ex_wdata,
  input  logic [4:0]       ex_rd,
  output logic [17:0]      perip_addr,
  output logic [31:0]      perip_wdata,
  output logic [1:0]       perip_mask,
  output logic             dram_wen,
  input  logic [31:0]      perip_rdata,
  input  logic [LED_W-1:0] sw,
  output logic [LED_W-1:0] led,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic             misalign,
  output logic             misalign_sticky
);

  region_e     region;
  logic        mis;
  logic        access;
  logic        do_load;
  logic        do_store;
  logic [31:0] counter;
  logic [31:0] ext_data;
  logic [31:0] load_data;

  assign perip_addr  = ex_addr[17:0];
  assign perip_wdata = ex_wdata;
  assign perip_mask  = ex_funct3[1:0];

  // Address decode: DRAM is a 256 KiB window, MMIO registers are exact matches.
  always_comb begin
    region = REG_NONE;
    if (ex_addr[31:18] == DRAM_BASE[31:18]) region = REG_DRAM;
    else if (ex_addr == MMIO_SW)            region = REG_SW;
    else if (ex_addr == MMIO_LED)           region = REG_LED;
    else if (ex_addr == MMIO_CNT)           region = REG_CNT;
  end

  // Alignment check from the access width.
  always_comb begin
    mis = 1'b0;
    case (ex_funct3[1:0])
      MASK_B:  mis = 1'b0;
      MASK_H:  mis = ex_addr[0];
      MASK_W:  mis = |ex_addr[1:0];
      default: mis = 1'b0;
    endcase
  end

  assign access   = ex_valid & (ex_is_load | ex_is_store);
  assign do_load  = ex_valid & ex_is_load;
  assign do_store = ex_valid & ex_is_store & ~mis;
  assign dram_wen = do_store & (region == REG_DRAM);

  load_extender u_ext (
    .funct3 (ex_funct3),
    .raw    (perip_rdata),
    .ext    (ext_data)
  );

  // Load source select; MMIO is always returned as a full word, misaligned loads as 0.
  always_comb begin
    load_data = '0;
    if (!mis) begin
      case (region)
        REG_DRAM: load_data = ext_data;
        REG_SW:   load_data = 32'(sw);
        REG_LED:  load_data = 32'(led);
        REG_CNT:  load_data = counter;
        default:  load_data = '0;
      endcase
    end
  end

  // Write-back register: one-cycle load latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= do_load;
      if (do_load) begin
        wb_rd   <= ex_rd;
        wb_data <= load_data;
      end
    end
  end

  // Misalignment pulse and sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign        <= 1'b0;
      misalign_sticky <= 1'b0;
    end else begin
      misalign <= access & mis;
      if (access & mis) misalign_sticky <= 1'b1;
    end
  end

  // MMIO registers: LED latch and free-running cycle counter (a store clears it).
  always_ff @(posedge clk) begin
    if (rst) begin
      led     <= '0;
      counter <= '0;
    end else begin
      if (do_store && region == REG_LED) led <= ex_wdata[LED_W-1:0];
      if (do_store && region == REG_CNT) counter <= '0;
      else                               counter <= counter + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a small dram_driver model.
module tb_mem_access_unit;

  localparam logic [31:0] A_SW  = 32'h8020_0000;
  localparam logic [31:0] A_LED = 32'h8020_0040;
  localparam logic [31:0] A_CNT = 32'h8020_0050;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_is_load = 1'b0;
  logic        ex_is_store = 1'b0;
  logic [2:0]  ex_funct3 = 3'b000;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_wdata = '0;
  logic [4:0]  ex_rd = '0;
  logic [17:0] perip_addr;
  logic [31:0] perip_wdata;
  logic [1:0]  perip_mask;
  logic        dram_wen;
  logic [31:0] perip_rdata;
  logic [23:0] sw = '0;
  logic [23:0] led;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;
  logic        misalign_sticky;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_unit #(.LED_W(24)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd), .perip_addr(perip_addr),
    .perip_wdata(perip_wdata), .perip_mask(perip_mask), .dram_wen(dram_wen),
    .perip_rdata(perip_rdata), .sw(sw), .led(led), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign),
    .misalign_sticky(misalign_sticky)
  );

  always #5 clk = ~clk;

  // dram_driver model: little-endian byte/half/word lanes, zero-extended reads.
  logic [31:0] mem [0:255];
  logic [31:0] mem_word;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (dram_wen) begin
      case (perip_mask)
        2'b00:   mem[perip_addr[9:2]][{perip_addr[1:0], 3'b000} +: 8] <= perip_wdata[7:0];
        2'b01:   mem[perip_addr[9:2]][{perip_addr[1], 4'b0000} +: 16] <= perip_wdata[15:0];
        default: mem[perip_addr[9:2]] <= perip_wdata;
      endcase
    end
  end

  always_comb begin
    mem_word = mem[perip_addr[9:2]];
    case (perip_mask)
      2'b00:   perip_rdata = {24'h0, mem_word[{perip_addr[1:0], 3'b000} +: 8]};
      2'b01:   perip_rdata = {16'h0, mem_word[{perip_addr[1], 4'b0000} +: 16]};
      default: perip_rdata = mem_word;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one request at the negedge; returns #1 later so comb outputs can be checked.
  task automatic present(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    @(negedge clk);
    ex_valid = v; ex_is_load = ld; ex_is_store = st;
    ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
    #1;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL rst_wb_valid: got %0b expected 0", wb_valid); end
    n_cmp++; if (wb_rd !== 5'd0) begin n_err++; $display("FAIL rst_wb_rd: got %0d expected 0", wb_rd); end
    n_cmp++; if (wb_data !== 32'd0) begin n_err++; $display("FAIL rst_wb_data: got %h expected 0", wb_data); end
    n_cmp++; if (led !== 24'd0) begin n_err++; $display("FAIL rst_led: got %h expected 0", led); end
    n_cmp++; if (misalign !== 1'b0 || misalign_sticky !== 1'b0) begin
      n_err++; $display("FAIL rst_misalign: got %0b/%0b expected 0/0", misalign, misalign_sticky); end
    n_cmp++; if (dram_wen !== 1'b0) begin n_err++; $display("FAIL rst_dram_wen: got %0b expected 0", dram_wen); end
  endtask

  // Counter is 0 in the first cycle after reset; a load in cycle 5 sees 5 (no extra offset).
  task automatic test_counter_start();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL idle_wb_valid[%0d]: got %0b expected 0", i, wb_valid); end
    end
    present(1, 1, 0, 3'b010, A_CNT, 32'h0, 5'd7);
    settle();
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 5'd7) begin
      n_err++; $display("FAIL cnt_start_valid: got %0b/%0d expected 1/7", wb_valid, wb_rd); end
    n_cmp++; if (wb_data !== 32'd5) begin n_err++; $display("FAIL cnt_start_data: got %h expected 00000005", wb_data); end
  endtask

  task automatic test_dram_store_load();
    present(1, 0, 1, 3'b010, 32'h8010_0008, 32'hDEAD_BEEF, 5'd0);
    n_cmp++; if (dram_wen !== 1'b1) begin n_err++; $display("FAIL sw_dram_wen: got %0b expected 1", dram_wen); end
    n_cmp++; if (perip_addr !== 18'h00008 || perip_mask !== 2'b10) begin
      n_err++; $display("FAIL sw_perip: got %h/%b expected 00008/10", perip_addr, perip_mask); end
    settle();
    n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL sw_wb_valid: got %0b expected 0", wb_valid); end
    present(1, 1, 0, 3'b000, 32'h8010_000B, 32'h0, 5'd3);
    n_cmp++; if (dram_wen !== 1'b0) begin n_err++; $display("FAIL lb_dram_wen: got %0b expected 0", dram_wen); end
    settle();
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'hFFFF_FFDE) begin
      n_err++; $display("FAIL lb_sext: got %0b/%0d/%h expected 1/3/ffffffde", wb_valid, wb_rd, wb_data); end
    present(1, 1, 0, 3'b100, 32'h8010_000B, 32'h0, 5'd4);
    settle();
    n_cmp++; if (wb_data !== 32'h0000_00DE) begin n_err++; $display("FAIL lbu_zext: got %h expected 000000de", wb_data); end
    present(1, 1, 0, 3'b001, 32'h8010_000A, 32'h0, 5'd5);
    settle();
    n_cmp++; if (wb_data !== 32'hFFFF_DEAD) begin n_err++; $display("FAIL lh_sext: got %h expected ffffdead", wb_data); end
    present(1, 1, 0, 3'b101, 32'h8010_000A, 32'h0, 5'd6);
    settle();
    n_cmp++; if (wb_data !== 32'h0000_DEAD) begin n_err++; $display("FAIL lhu_zext: got %h expected 0000dead", wb_data); end
    present(1, 1, 0, 3'b010, 32'h8010_0008, 32'h0, 5'd8);
    settle();
    n_cmp++; if (wb_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lw_word: got %h expected deadbeef", wb_data); end
    // Byte store then immediate word load of the same word.
    present(1, 0, 1, 3'b000, 32'h8010_0009, 32'h0000_0042, 5'd0);
    n_cmp++; if (dram_wen !== 1'b1) begin n_err++; $display("FAIL sb_dram_wen: got %0b expected 1", dram_wen); end
    settle();
    present(1, 1, 0, 3'b010, 32'h8010_0008, 32'h0, 5'd9);
    settle();
    n_cmp++; if (wb_data !== 32'hDEAD_42EF) begin n_err++; $display("FAIL b2b_lw: got %h expected dead42ef", wb_data); end
  endtask

  task automatic test_misalign();
    present(1, 1, 0, 3'b001, 32'h8010_0001, 32'h0, 5'd10);
    settle();
    n_cmp++; if (misalign !== 1'b1 || misalign_sticky !== 1'b1) begin
      n_err++; $display("FAIL mis_lh_flags: got %0b/%0b expected 1/1", misalign, misalign_sticky); end
    n_cmp++; if (wb_valid !== 1'b1 || wb_rd !== 5'd10 || wb_data !== 32'd0) begin
      n_err++; $display("FAIL mis_lh_wb: got %0b/%0d/%h expected 1/10/0", wb_valid, wb_rd, wb_data); end
    present(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
    settle();
    n_cmp++; if (misalign !== 1'b0 || misalign_sticky !== 1'b1) begin
      n_err++; $display("FAIL mis_pulse_end: got %0b/%0b expected 0/1", misalign, misalign_sticky); end
    present(1, 0, 1, 3'b010, 32'h8010_0002, 32'h1111_1111, 5'd0);
    n_cmp++; if (dram_wen !== 1'b0) begin n_err++; $display("FAIL mis_sw_wen: got %0b expected 0", dram_wen); end
    settle();
    n_cmp++; if (misalign !== 1'b1) begin n_err++; $display("FAIL mis_sw_pulse: got %0b expected 1", misalign); end
    present(1, 1, 0, 3'b010, 32'h8010_0000, 32'h0, 5'd11);
    settle();
    n_cmp++; if (wb_data !== 32'd0) begin n_err++; $display("FAIL mis_sw_mem: got %h expected 00000000", wb_data); end
  endtask

  task automatic test_mmio_led();
    present(1, 0, 1, 3'b010, A_LED, 32'h00AB_CDEF, 5'd0);
    n_cmp++; if (dram_wen !== 1'b0) begin n_err++; $display("FAIL led_dram_wen: got %0b expected 0", dram_wen); end
    settle();
    n_cmp++; if (led !== 24'hAB_CDEF) begin n_err++; $display("FAIL led_store: got %h expected abcdef", led); end
    present(1, 1, 0, 3'b010, A_LED, 32'h0, 5'd12);
    settle();
    n_cmp++; if (wb_data !== 32'h00AB_CDEF) begin n_err++; $display("FAIL led_load: got %h expected 00abcdef", wb_data); end
    present(1, 0, 1, 3'b000, A_LED, 32'h1234_5655, 5'd0);
    settle();
    n_cmp++; if (led !== 24'h34_5655) begin n_err++; $display("FAIL led_sb: got %h expected 345655", led); end
  endtask

  task automatic test_mmio_sw();
    sw = 24'h12_3456;
    present(1, 0, 1, 3'b010, A_SW, 32'hFFFF_FFFF, 5'd0);
    n_cmp++; if (dram_wen !== 1'b0) begin n_err++; $display("FAIL swreg_dram_wen: got %0b expected 0", dram_wen); end
    settle();
    present(1, 1, 0, 3'b010, A_SW, 32'h0, 5'd13);
    settle();
    n_cmp++; if (wb_data !== 32'h0012_3456) begin n_err++; $display("FAIL swreg_load: got %h expected 00123456", wb_data); end
    n_cmp++; if (led !== 24'h34_5655) begin n_err++; $display("FAIL swreg_led_kept: got %h expected 345655", led); end
    sw = 24'hAB_CD80;
    present(1, 1, 0, 3'b000, A_SW, 32'h0, 5'd14);
    settle();
    n_cmp++; if (wb_data !== 32'h00AB_CD80) begin n_err++; $display("FAIL swreg_lb_full: got %h expected 00abcd80", wb_data); end
    present(1, 1, 0, 3'b010, 32'h8030_0000, 32'h0, 5'd15);
    settle();
    n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'd0) begin
      n_err++; $display("FAIL unmapped_load: got %0b/%h expected 1/00000000", wb_valid, wb_data); end
  endtask

  task automatic test_counter_wrap();
    @(negedge clk);
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    force dut.counter = 32'hFFFF_FFFE;
    #1;
    release dut.counter;
    present(1, 1, 0, 3'b010, A_CNT, 32'h0, 5'd16);
    settle();
    n_cmp++; if (wb_data !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL cnt_max: got %h expected ffffffff", wb_data); end
    present(1, 1, 0, 3'b010, A_CNT, 32'h0, 5'd17);
    settle();
    n_cmp++; if (wb_data !== 32'd0) begin n_err++; $display("FAIL cnt_wrap: got %h expected 00000000", wb_data); end
    repeat (3) settle();
    present(1, 0, 1, 3'b010, A_CNT, 32'h0, 5'd0);
    settle();
    present(1, 1, 0, 3'b010, A_CNT, 32'h0, 5'd18);
    settle();
    n_cmp++; if (wb_data !== 32'd0) begin n_err++; $display("FAIL cnt_clear: got %h expected 00000000", wb_data); end
    present(1, 1, 0, 3'b010, A_CNT, 32'h0, 5'd19);
    settle();
    n_cmp++; if (wb_data !== 32'd1) begin n_err++; $display("FAIL cnt_after_clear: got %h expected 00000001", wb_data); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst = 1'b1;
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_is_store = 1'b1;
    ex_funct3 = 3'b010; ex_addr = A_LED; ex_wdata = 32'h0077_7777; ex_rd = 5'd0;
    settle();
    n_cmp++; if (led !== 24'd0) begin n_err++; $display("FAIL rstmid_led: got %h expected 000000", led); end
    n_cmp++; if (misalign_sticky !== 1'b0) begin n_err++; $display("FAIL rstmid_sticky: got %0b expected 0", misalign_sticky); end
    present(1, 1, 0, 3'b010, A_SW, 32'h0, 5'd20);
    settle();
    n_cmp++; if (wb_valid !== 1'b0 || wb_data !== 32'd0) begin
      n_err++; $display("FAIL rstmid_load: got %0b/%h expected 0/00000000", wb_valid, wb_data); end
    @(negedge clk);
    rst = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
    settle();
    n_cmp++; if (led !== 24'd0 || wb_valid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_after: got %h/%0b expected 000000/0", led, wb_valid); end
  endtask

  initial begin
    test_reset();
    test_counter_start();
    test_dram_store_load();
    test_misalign();
    test_mmio_led();
    test_mmio_sw();
    test_counter_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
